// File: rtl/risc32i_pkg.sv
// Shared risc32i definitions: opcodes, hazard classes, pipeline stage indices
// and the hazard scoreboard entry.
package risc32i_pkg;

   localparam int unsigned SB_RD_W = 8;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      HZ_REGISTER  = 3'd0,
      HZ_LOAD      = 3'd1,
      HZ_STORE     = 3'd2,
      HZ_IMMEDIATE = 3'd3,
      HZ_UPPERIMM  = 3'd4,
      HZ_BRANCH    = 3'd5
   } hz_type_e;

   typedef enum logic [1:0] {
      ST_DECODE    = 2'd0,
      ST_EXECUTE   = 2'd1,
      ST_MEMORY    = 2'd2,
      ST_WRITEBACK = 2'd3
   } stage_e;

   // rd is held at a fixed width so one struct serves every REG_W up to SB_RD_W
   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               is_load;
      logic               is_branch;
      logic               writes;
   } sb_entry_t;

   function automatic logic type_writes(input logic [2:0] t);
      return t inside {HZ_REGISTER, HZ_LOAD, HZ_IMMEDIATE, HZ_UPPERIMM};
   endfunction

   function automatic logic uses_rs1(input logic [2:0] t);
      return t inside {HZ_REGISTER, HZ_LOAD, HZ_STORE, HZ_IMMEDIATE, HZ_BRANCH};
   endfunction

   function automatic logic uses_rs2(input logic [2:0] t);
      return t inside {HZ_REGISTER, HZ_STORE, HZ_BRANCH};
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one decode source register against the in-flight
// scoreboard; the youngest (lowest stage index) writer wins.
module hazard_src_match
   import risc32i_pkg::*;
#(
   parameter  int unsigned NUM_STAGES = 3,
   localparam int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  sb_entry_t [NUM_STAGES:1] sb,
   input  logic                     used,
   input  logic [SB_RD_W-1:0]       rs,
   output logic                     hit,
   output logic [SEL_W-1:0]         stage,
   output logic                     is_load
);

   // Scan oldest to youngest so the last assignment is the youngest match
   always_comb begin
      hit     = 1'b0;
      stage   = '0;
      is_load = 1'b0;
      for (int k = int'(NUM_STAGES); k >= 1; k--) begin
         if (used && (rs != '0) && sb[k].valid && sb[k].writes && (sb[k].rd == rs)) begin
            hit     = 1'b1;
            stage   = SEL_W'(k);
            is_load = sb[k].is_load;
         end
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: issue/stall/flush decision and operand forwarding
// selects from a shifting scoreboard of in-flight destination registers.
module hazard_unit
   import risc32i_pkg::*;
#(
   parameter  int unsigned NUM_STAGES = 3,
   parameter  int unsigned FORWARDING = 1,
   parameter  int unsigned REG_W      = 5,
   parameter  int unsigned CNT_W      = 32,
   localparam int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dec_valid,
   input  logic [2:0]       dec_type,
   input  logic [REG_W-1:0] dec_rs1,
   input  logic [REG_W-1:0] dec_rs2,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             branch_taken,
   output logic             issue,
   output logic             stall,
   output logic             flush,
   output logic [SEL_W-1:0] fwd_rs1_sel,
   output logic [SEL_W-1:0] fwd_rs2_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   sb_entry_t [NUM_STAGES:1] sb;
   sb_entry_t                dec_entry;
   logic                     use1, use2;
   logic                     hit1, hit2, ld1, ld2, haz1, haz2;
   logic [SEL_W-1:0]         stg1, stg2;

   assign use1 = dec_valid && uses_rs1(dec_type);
   assign use2 = dec_valid && uses_rs2(dec_type);

   hazard_src_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs1 (
      .sb      (sb),
      .used    (use1),
      .rs      (SB_RD_W'(dec_rs1)),
      .hit     (hit1),
      .stage   (stg1),
      .is_load (ld1)
   );

   hazard_src_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs2 (
      .sb      (sb),
      .used    (use2),
      .rs      (SB_RD_W'(dec_rs2)),
      .hit     (hit2),
      .stage   (stg2),
      .is_load (ld2)
   );

   // Stall-only mode can read the final stage through the write-through register file
   always_comb begin
      haz1 = 1'b0;
      haz2 = 1'b0;
      if (FORWARDING != 0) begin
         haz1 = hit1 && (stg1 == SEL_W'(1)) && ld1;
         haz2 = hit2 && (stg2 == SEL_W'(1)) && ld2;
      end else begin
         haz1 = hit1 && (stg1 != SEL_W'(NUM_STAGES));
         haz2 = hit2 && (stg2 != SEL_W'(NUM_STAGES));
      end
   end

   // A taken branch in EXECUTE squashes decode and overrides any hazard
   always_comb begin
      flush       = branch_taken && sb[1].valid && sb[1].is_branch;
      stall       = (haz1 || haz2) && !flush;
      issue       = dec_valid && !stall && !flush;
      fwd_rs1_sel = ((FORWARDING != 0) && hit1 && !haz1) ? stg1 : '0;
      fwd_rs2_sel = ((FORWARDING != 0) && hit2 && !haz2) ? stg2 : '0;
   end

   always_comb begin
      dec_entry           = '0;
      dec_entry.valid     = 1'b1;
      dec_entry.rd        = SB_RD_W'(dec_rd);
      dec_entry.is_load   = (dec_type == HZ_LOAD);
      dec_entry.is_branch = (dec_type == HZ_BRANCH);
      dec_entry.writes    = type_writes(dec_type) && (dec_rd != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sb          <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         sb[1] <= issue ? dec_entry : '0;
         for (int k = 2; k <= int'(NUM_STAGES); k++) begin
            sb[k] <= sb[k-1];
         end
         if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
         if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
